// File: rtl/ex_muldiv_if.sv
// -----------------------------------------------------------------------------
// ex_muldiv_iter_if
// Request/response bundle between the execute stage and the iterative
// multiply/divide unit.
//   flush               kill any in-flight op (branch/exception)
//   in_valid/in_ready   request handshake; in_op is RISC-V funct3
//                       (0 MUL 1 MULH 2 MULHSU 3 MULHU 4 DIV 5 DIVU 6 REM 7 REMU)
//   in_a/in_b/in_tag    operands and destination tag
//   out_valid/out_ready result handshake; out_res/out_tag result and its tag
//   busy                unit is not idle (execute holds EX/MEM)
// master = execute stage, slave = multiply/divide unit.
// -----------------------------------------------------------------------------
interface ex_muldiv_iter_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [XLEN-1:0]  in_a;
  logic [XLEN-1:0]  in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_res;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  modport master (
    output flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    input  in_ready, out_valid, out_res, out_tag, busy
  );

  modport slave (
    input  flush, in_valid, in_op, in_a, in_b, in_tag, out_ready,
    output in_ready, out_valid, out_res, out_tag, busy
  );
endinterface

// File: rtl/ex_muldiv_iter.sv
// -----------------------------------------------------------------------------
// ex_muldiv_iter
// Iterative RV32M/RV64M multiply/divide unit for the execute stage.
//   clk   system clock
//   Rst   asynchronous active-low reset
//   bus   ex_muldiv_iter_if.slave (request, result and busy signals)
// Multiply: shift-add on a 2*XLEN accumulator, MUL_BITS multiplier bits per
// cycle (XLEN/MUL_BITS cycles) plus one sign-fixup cycle.
// Divide: restoring radix-2 on magnitudes (XLEN cycles) plus one fixup cycle.
// Optional macro MULDIV_EARLY_OUT_EN: divide by zero, signed overflow and
// multiplies with a zero operand skip iteration (result one cycle after
// accept). Results are identical either way.
// -----------------------------------------------------------------------------
module ex_muldiv_iter #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned MUL_BITS = 2,
  parameter int unsigned TAG_W    = 5
) (
  input logic               clk,
  input logic               Rst,
  ex_muldiv_iter_if.slave   bus
);

  localparam int unsigned    CW        = $clog2(XLEN + 1);
  localparam logic [CW-1:0]  MUL_ITERS = CW'(XLEN / MUL_BITS);
  localparam logic [CW-1:0]  DIV_ITERS = CW'(XLEN);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state_q,    state_d;
  logic [CW-1:0]     cnt_q,      cnt_d;
  logic [2:0]        op_q,       op_d;
  logic [TAG_W-1:0]  tag_q,      tag_d;
  logic              neg_q,      neg_d;
  logic              spec_q,     spec_d;
  logic [XLEN-1:0]   spec_res_q, spec_res_d;
  logic [XLEN-1:0]   mcand_q,    mcand_d;
  logic [2*XLEN-1:0] acc_q,      acc_d;
  logic [XLEN-1:0]   res_q,      res_d;

  // ---------------- request decode ----------------
  logic            accept, is_div, a_sgn, b_sgn, a_neg, b_neg, res_neg;
  logic            div0, ovf, mulz, special, early;
  logic [XLEN-1:0] a_mag, b_mag, spec_val;

  always_comb begin
    accept  = bus.in_valid && (state_q == S_IDLE) && !bus.flush;
    is_div  = bus.in_op[2];
    a_sgn   = is_div ? ~bus.in_op[0] : (bus.in_op == 3'd1 || bus.in_op == 3'd2);
    b_sgn   = is_div ? ~bus.in_op[0] : (bus.in_op == 3'd1);
    a_neg   = a_sgn & bus.in_a[XLEN-1];
    b_neg   = b_sgn & bus.in_b[XLEN-1];
    a_mag   = a_neg ? -bus.in_a : bus.in_a;
    b_mag   = b_neg ? -bus.in_b : bus.in_b;
    // REM/REMU take the dividend's sign; everything else a^b
    res_neg = (is_div & bus.in_op[1]) ? a_neg : (a_neg ^ b_neg);
    div0    = is_div & (bus.in_b == '0);
    ovf     = is_div & ~bus.in_op[0] & (bus.in_a == {1'b1, {(XLEN-1){1'b0}}})
              & (bus.in_b == '1);
    mulz    = ~is_div & ((bus.in_a == '0) | (bus.in_b == '0));
    special = div0 | ovf | mulz;
    if (div0)     spec_val = bus.in_op[1] ? bus.in_a : '1;
    else if (ovf) spec_val = bus.in_op[1] ? '0 : bus.in_a;
    else          spec_val = '0;
  end

`ifdef MULDIV_EARLY_OUT_EN
  assign early = special;
`else
  assign early = 1'b0;
`endif

  // ---------------- datapath steps ----------------
  logic [MUL_BITS-1:0]      digit;
  logic [XLEN+MUL_BITS-1:0] hi_sum;
  logic [2*XLEN-1:0]        mul_next, div_next, prod;
  logic [XLEN:0]            rem_sh, rem_sub;
  logic                     ge;
  logic [XLEN-1:0]          div_mag, div_res, mul_res, fix_res;

  always_comb begin
    // multiplier sits in the low half and shifts out MUL_BITS per step
    digit    = acc_q[MUL_BITS-1:0];
    hi_sum   = (XLEN+MUL_BITS)'(acc_q[2*XLEN-1:XLEN])
             + (XLEN+MUL_BITS)'(mcand_q) * (XLEN+MUL_BITS)'(digit);
    mul_next = {hi_sum, acc_q[XLEN-1:MUL_BITS]};

    // acc = {remainder, dividend/quotient}
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    rem_sub  = rem_sh - {1'b0, mcand_q};
    ge       = rem_sh >= {1'b0, mcand_q};
    div_next = {(ge ? rem_sub[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};

    prod     = neg_q ? -acc_q : acc_q;
    mul_res  = (op_q[1:0] == 2'd0) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    div_mag  = op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    div_res  = neg_q ? -div_mag : div_mag;
    fix_res  = spec_q ? spec_res_q : (op_q[2] ? div_res : mul_res);
  end

  // ---------------- control ----------------
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    tag_d      = tag_q;
    neg_d      = neg_q;
    spec_d     = spec_q;
    spec_res_d = spec_res_q;
    mcand_d    = mcand_q;
    acc_d      = acc_q;
    res_d      = res_q;
    case (state_q)
      S_IDLE: if (accept) begin
        op_d       = bus.in_op;
        tag_d      = bus.in_tag;
        neg_d      = res_neg;
        spec_d     = special;
        spec_res_d = spec_val;
        mcand_d    = is_div ? b_mag : a_mag;
        acc_d      = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
        state_d    = is_div ? S_DIV : S_MUL;
        // early-out jumps the counter straight to the fixup step
        cnt_d      = early ? (is_div ? DIV_ITERS : MUL_ITERS) : '0;
      end
      S_MUL: if (cnt_q == MUL_ITERS) begin
        res_d   = fix_res;
        cnt_d   = '0;
        state_d = S_DONE;
      end else begin
        acc_d = mul_next;
        cnt_d = cnt_q + CW'(1);
      end
      S_DIV: if (cnt_q == DIV_ITERS) begin
        res_d   = fix_res;
        cnt_d   = '0;
        state_d = S_DONE;
      end else begin
        acc_d = div_next;
        cnt_d = cnt_q + CW'(1);
      end
      default: if (bus.out_ready) state_d = S_IDLE;
    endcase
    if (bus.flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      res_d   = res_q;
    end
  end

  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      tag_q      <= '0;
      neg_q      <= 1'b0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      mcand_q    <= '0;
      acc_q      <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      tag_q      <= tag_d;
      neg_q      <= neg_d;
      spec_q     <= spec_d;
      spec_res_q <= spec_res_d;
      mcand_q    <= mcand_d;
      acc_q      <= acc_d;
      res_q      <= res_d;
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_res   = res_q;
  assign bus.out_tag   = tag_q;

endmodule
